// File: rtl/eth_csr_avmm_bridge.sv
// Turns the flat Ethernet CSR command/data registers into single Avalon-MM
// transactions, with a bus timeout so a hung slave cannot wedge software.
module eth_csr_avmm_bridge #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] eth_ctrl_addr,
  input  logic [31:0] eth_wr_data,
  output logic [31:0] eth_rd_data,
  output logic [15:0] avmm_address,
  output logic        avmm_write,
  output logic        avmm_read,
  output logic [31:0] avmm_writedata,
  input  logic [31:0] avmm_readdata,
  input  logic        avmm_readdatavalid,
  input  logic        avmm_waitrequest,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    cmd;
  logic          timeout_hit;
  logic          unused_bits;

  assign cmd         = eth_ctrl_addr[17:16];
  assign unused_bits = ^eth_ctrl_addr[31:18];

  // ">=" rather than "==": an accepted read enters RD_WAIT with the count
  // possibly already at the limit, and must still time out there.
  assign timeout_hit = (cnt_reg >= CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      eth_rd_data    <= '0;
      avmm_address   <= '0;
      avmm_write     <= 1'b0;
      avmm_read      <= 1'b0;
      avmm_writedata <= '0;
      busy           <= 1'b0;
      err            <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          case (cmd)
            2'b01: begin
              avmm_address   <= eth_ctrl_addr[15:0];
              avmm_writedata <= eth_wr_data;
              avmm_write     <= 1'b1;
              err            <= 1'b0;
              busy           <= 1'b1;
              state_reg      <= WR;
            end
            2'b10: begin
              avmm_address <= eth_ctrl_addr[15:0];
              avmm_read    <= 1'b1;
              err          <= 1'b0;
              busy         <= 1'b1;
              state_reg    <= RD_REQ;
            end
            2'b11: begin
              err       <= 1'b1;
              busy      <= 1'b1;
              state_reg <= DONE;
            end
            default: ;
          endcase
        end

        WR: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (!avmm_waitrequest) begin
            avmm_write <= 1'b0;
            state_reg  <= DONE;
          end else if (timeout_hit) begin
            avmm_write <= 1'b0;
            err        <= 1'b1;
            state_reg  <= DONE;
          end
        end

        RD_REQ: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (!avmm_waitrequest) begin
            avmm_read <= 1'b0;
            state_reg <= RD_WAIT;
          end else if (timeout_hit) begin
            avmm_read   <= 1'b0;
            err         <= 1'b1;
            eth_rd_data <= TIMEOUT_DATA;
            state_reg   <= DONE;
          end
        end

        RD_WAIT: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (avmm_readdatavalid) begin
            eth_rd_data <= avmm_readdata;
            state_reg   <= DONE;
          end else if (timeout_hit) begin
            err         <= 1'b1;
            eth_rd_data <= TIMEOUT_DATA;
            state_reg   <= DONE;
          end
        end

        DONE: begin
          // Level-based rearm: a held command bit never re-issues.
          if (cmd == 2'b00) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: begin
          avmm_write <= 1'b0;
          avmm_read  <= 1'b0;
          busy       <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_csr_avmm_bridge.sv
// Directed bench for eth_csr_avmm_bridge: write, stalled read, timeout,
// illegal/held commands, late response and reset mid-read.
module tb_eth_csr_avmm_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] eth_ctrl_addr;
  logic [31:0] eth_wr_data;
  logic [31:0] eth_rd_data;
  logic [15:0] avmm_address;
  logic        avmm_write;
  logic        avmm_read;
  logic [31:0] avmm_writedata;
  logic [31:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic        avmm_waitrequest;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int hi_cnt;

  eth_csr_avmm_bridge #(
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .eth_ctrl_addr     (eth_ctrl_addr),
    .eth_wr_data       (eth_wr_data),
    .eth_rd_data       (eth_rd_data),
    .avmm_address      (avmm_address),
    .avmm_write        (avmm_write),
    .avmm_read         (avmm_read),
    .avmm_writedata    (avmm_writedata),
    .avmm_readdata     (avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid),
    .avmm_waitrequest  (avmm_waitrequest),
    .busy              (busy),
    .err               (err)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset              = 1'b1;
    eth_ctrl_addr      = '0;
    eth_wr_data        = '0;
    avmm_readdata      = '0;
    avmm_readdatavalid = 1'b0;
    avmm_waitrequest   = 1'b0;
    tick();
    tick();
    chk("rst_rd_data", eth_rd_data, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_req", {30'b0, avmm_write, avmm_read}, 32'h0);
    chk("rst_addr", {16'b0, avmm_address}, 32'h0);
    reset = 1'b0;
    tick();

    // Write, no waitrequest
    eth_ctrl_addr = 32'h0001_0123;
    eth_wr_data   = 32'hA5A5_5A5A;
    tick();
    chk("wr_pulse", {31'b0, avmm_write}, 32'h1);
    chk("wr_addr", {16'b0, avmm_address}, 32'h0000_0123);
    chk("wr_data", avmm_writedata, 32'hA5A5_5A5A);
    chk("wr_busy", {31'b0, busy}, 32'h1);
    tick();
    chk("wr_drop", {31'b0, avmm_write}, 32'h0);
    chk("wr_done_busy", {31'b0, busy}, 32'h1);
    chk("wr_err", {31'b0, err}, 32'h0);
    eth_ctrl_addr = 32'h0;
    tick();
    chk("wr_idle_busy", {31'b0, busy}, 32'h0);
    $display("txn write addr=0123 data=a5a55a5a");

    // Read with 3 stall cycles, response 2 cycles after accept
    eth_ctrl_addr    = 32'h0002_0040;
    avmm_waitrequest = 1'b1;
    tick();
    chk("rd_c1", {31'b0, avmm_read}, 32'h1);
    eth_ctrl_addr = 32'h0002_0099;
    tick();
    chk("rd_c2", {31'b0, avmm_read}, 32'h1);
    chk("rd_addr_hold", {16'b0, avmm_address}, 32'h0000_0040);
    tick();
    chk("rd_c3", {31'b0, avmm_read}, 32'h1);
    tick();
    chk("rd_c4", {31'b0, avmm_read}, 32'h1);
    avmm_waitrequest = 1'b0;
    tick();
    chk("rd_c5_drop", {31'b0, avmm_read}, 32'h0);
    tick();
    avmm_readdatavalid = 1'b1;
    avmm_readdata      = 32'h1234_5678;
    chk("rd_before_data", eth_rd_data, 32'h0);
    tick();
    avmm_readdatavalid = 1'b0;
    chk("rd_data", eth_rd_data, 32'h1234_5678);
    chk("rd_err", {31'b0, err}, 32'h0);
    eth_ctrl_addr = 32'h0;
    tick();
    chk("rd_idle_busy", {31'b0, busy}, 32'h0);
    $display("txn read addr=0040 data=%h", eth_rd_data);

    // Timeout: waitrequest stuck high
    eth_ctrl_addr    = 32'h0002_0010;
    avmm_waitrequest = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (avmm_read) hi_cnt++;
    end
    chk("to_read_cycles", hi_cnt, 32'd16);
    chk("to_rd_data", eth_rd_data, 32'hDEAD_BEEF);
    chk("to_err", {31'b0, err}, 32'h1);
    avmm_readdatavalid = 1'b1;
    avmm_readdata      = 32'hFFFF_0000;
    tick();
    avmm_readdatavalid = 1'b0;
    tick();
    chk("late_rsp_ignored", eth_rd_data, 32'hDEAD_BEEF);
    eth_ctrl_addr    = 32'h0;
    avmm_waitrequest = 1'b0;
    tick();
    $display("txn read addr=0010 timeout data=%h", eth_rd_data);

    // Write after timeout clears err
    eth_ctrl_addr = 32'h0001_0001;
    eth_wr_data   = 32'h0000_0001;
    tick();
    chk("wr_clears_err", {31'b0, err}, 32'h0);
    tick();
    eth_ctrl_addr = 32'h0;
    tick();
    $display("txn write addr=0001 data=00000001");

    // Illegal command
    eth_ctrl_addr = 32'h0003_0007;
    hi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (avmm_read || avmm_write) hi_cnt++;
    end
    chk("ill_no_bus", hi_cnt, 32'd0);
    chk("ill_err", {31'b0, err}, 32'h1);
    chk("ill_busy", {31'b0, busy}, 32'h1);
    eth_ctrl_addr = 32'h0;
    tick();
    chk("ill_err_sticky", {31'b0, err}, 32'h1);
    $display("txn illegal cmd=11");

    // Held write command issues exactly once
    eth_ctrl_addr = 32'h0001_0005;
    eth_wr_data   = 32'h5555_AAAA;
    hi_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (avmm_write) hi_cnt++;
    end
    chk("held_wr_once", hi_cnt, 32'd1);
    chk("held_wr_err", {31'b0, err}, 32'h0);
    eth_ctrl_addr = 32'h0;
    tick();
    $display("txn write held addr=0005 pulses=%0d", hi_cnt);

    // Reset while in RD_WAIT
    eth_ctrl_addr = 32'h0002_0020;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_read", {31'b0, avmm_read}, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_rd_data", eth_rd_data, 32'h0);
    chk("rst_mid_err", {31'b0, err}, 32'h0);
    reset = 1'b0;
    tick();
    chk("post_rst_reissue", {31'b0, avmm_read}, 32'h1);
    chk("post_rst_busy", {31'b0, busy}, 32'h1);
    tick();
    avmm_readdatavalid = 1'b1;
    avmm_readdata      = 32'hCAFE_F00D;
    tick();
    avmm_readdatavalid = 1'b0;
    chk("post_rst_rd_data", eth_rd_data, 32'hCAFE_F00D);
    eth_ctrl_addr = 32'h0;
    tick();
    $display("txn read addr=0020 after reset data=%h", eth_rd_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
